// File: rtl/dual_prio_decoder.sv
// Decodes a latched pair of priority codes into one-hot grants and plays
// them out for HOLD cycles each, ending with a single-cycle done tick.
module dual_prio_decoder #(
    parameter int N    = 12,
    parameter int W    = 4,
    parameter int HOLD = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] first,
    input  logic [W-1:0] second,
    output logic         ready,
    output logic [N:1]   grant,
    output logic [N:1]   mask,
    output logic         done_tick
);

    localparam int CW = $clog2(HOLD) + 1;
    localparam logic [CW-1:0] RELOAD = CW'(HOLD - 1);

    typedef enum logic [1:0] {
        IDLE,
        G1,
        G2,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  first_q, first_d;
    logic [W-1:0]  second_q, second_d;
    logic [N:1]    mask_q, mask_d;
    logic [N:1]    grant_q, grant_d;
    logic          ready_q, ready_d;
    logic          done_q, done_d;

    function automatic logic code_valid(input logic [W-1:0] c);
        return (c != '0) && (int'(c) <= N);
    endfunction

    function automatic logic [N:1] decode(input logic [W-1:0] c);
        logic [N:1] v;
        v = '0;
        for (int i = 1; i <= N; i++) begin
            if (int'(c) == i) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

    // The second code only plays when it adds a new, valid grant behind a valid first.
    function automatic logic second_plays(input logic [W-1:0] f, input logic [W-1:0] s);
        return code_valid(f) && code_valid(s) && (s != f);
    endfunction

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        first_d  = first_q;
        second_d = second_q;
        mask_d   = mask_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    first_d  = first;
                    second_d = second;
                    mask_d   = decode(first) |
                               (second_plays(first, second) ? decode(second) : '0);
                    cnt_d    = RELOAD;
                    state_d  = code_valid(first) ? G1 : DONE;
                end
            end
            G1: begin
                if (cnt_q == '0) begin
                    cnt_d   = RELOAD;
                    state_d = second_plays(first_q, second_q) ? G2 : DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            G2: begin
                if (cnt_q == '0) begin
                    cnt_d   = RELOAD;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_comb begin
        ready_d = (state_d == IDLE);
        done_d  = (state_d == DONE);
        grant_d = '0;
        if (state_d == G1) begin
            grant_d = decode(first_d);
        end else if (state_d == G2) begin
            grant_d = decode(second_d);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            first_q  <= '0;
            second_q <= '0;
            mask_q   <= '0;
            grant_q  <= '0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            first_q  <= first_d;
            second_q <= second_d;
            mask_q   <= mask_d;
            grant_q  <= grant_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
        end
    end

    assign ready     = ready_q;
    assign grant     = grant_q;
    assign mask      = mask_q;
    assign done_tick = done_q;

endmodule

// File: tb/tb_dual_prio_decoder.sv
// Directed bench for dual_prio_decoder with HOLD=4, N=12, W=4.
module tb_dual_prio_decoder;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  first;
    logic [3:0]  second;
    logic        ready;
    logic [12:1] grant;
    logic [12:1] mask;
    logic        done_tick;

    int checks;
    int errors;

    dual_prio_decoder #(.N(12), .W(4), .HOLD(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .first     (first),
        .second    (second),
        .ready     (ready),
        .grant     (grant),
        .mask      (mask),
        .done_tick (done_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents a code pair for one edge; on return we sit in cycle 1 after E0.
    task automatic do_start(input logic [3:0] f, input logic [3:0] s);
        first  = f;
        second = s;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        first  = 4'hA;
        second = 4'hB;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        start  = 1'b0;
        first  = 4'd0;
        second = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        checks++;
        if (ready !== 1'b1 || grant !== 12'h000 || mask !== 12'h000 || done_tick !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_state: ready=%b grant=%h mask=%h done=%b, expected 1/000/000/0",
                     ready, grant, mask, done_tick);
        end
    endtask

    task automatic test_full_sequence();
        logic [12:1] eg;
        do_start(4'd12, 4'd3);
        for (int c = 1; c <= 10; c++) begin
            eg = (c <= 4) ? 12'h800 : (c <= 8) ? 12'h004 : 12'h000;
            checks++;
            if (grant !== eg || done_tick !== (c == 9) || ready !== (c == 10) || mask !== 12'h804) begin
                errors++;
                $display("[TB] FAIL full_c%0d: grant=%h done=%b ready=%b mask=%h, expected %h/%b/%b/804",
                         c, grant, done_tick, ready, mask, eg, (c == 9), (c == 10));
            end
            if (c < 10) next_cycle();
        end
    endtask

    task automatic test_same_codes();
        do_start(4'd5, 4'd5);
        for (int c = 1; c <= 6; c++) begin
            checks++;
            if (grant !== ((c <= 4) ? 12'h010 : 12'h000) || done_tick !== (c == 5) ||
                ready !== (c == 6) || mask !== 12'h010) begin
                errors++;
                $display("[TB] FAIL same_c%0d: grant=%h done=%b ready=%b mask=%h, expected %h/%b/%b/010",
                         c, grant, done_tick, ready, mask, (c <= 4) ? 12'h010 : 12'h000, (c == 5), (c == 6));
            end
            if (c < 6) next_cycle();
        end
    endtask

    task automatic test_invalid(input logic [3:0] f, input logic [3:0] s);
        do_start(f, s);
        for (int c = 1; c <= 2; c++) begin
            checks++;
            if (grant !== 12'h000 || done_tick !== (c == 1) || ready !== (c == 2) || mask !== 12'h000) begin
                errors++;
                $display("[TB] FAIL invalid_%0d_%0d_c%0d: grant=%h done=%b ready=%b mask=%h, expected 000/%b/%b/000",
                         f, s, c, grant, done_tick, ready, mask, (c == 1), (c == 2));
            end
            if (c < 2) next_cycle();
        end
    endtask

    task automatic test_ignore_start();
        logic [12:1] eg;
        do_start(4'd12, 4'd3);
        first  = 4'd5;
        second = 4'd6;
        start  = 1'b1;
        next_cycle();
        start = 1'b0;
        for (int c = 2; c <= 10; c++) begin
            eg = (c <= 4) ? 12'h800 : (c <= 8) ? 12'h004 : 12'h000;
            checks++;
            if (grant !== eg || done_tick !== (c == 9) || ready !== (c == 10) || mask !== 12'h804) begin
                errors++;
                $display("[TB] FAIL ignore_c%0d: grant=%h done=%b ready=%b mask=%h, expected %h/%b/%b/804",
                         c, grant, done_tick, ready, mask, eg, (c == 9), (c == 10));
            end
            if (c < 10) next_cycle();
        end
    endtask

    task automatic test_reset_mid();
        do_start(4'd12, 4'd3);
        repeat (5) next_cycle();
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (grant !== 12'h000 || mask !== 12'h000 || done_tick !== 1'b0 || ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_mid: grant=%h mask=%h done=%b ready=%b, expected 000/000/0/1",
                     grant, mask, done_tick, ready);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int c = 0; c < 12; c++) begin
            next_cycle();
            checks++;
            if (done_tick !== 1'b0 || ready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL reset_mid_after_%0d: done=%b ready=%b, expected 0/1", c, done_tick, ready);
            end
        end
    endtask

    task automatic test_back_to_back();
        first  = 4'd2;
        second = 4'd9;
        start  = 1'b1;
        next_cycle();
        checks++;
        if (grant !== 12'h002 || mask !== 12'h102) begin
            errors++;
            $display("[TB] FAIL b2b_first: grant=%h mask=%h, expected 002/102", grant, mask);
        end
        repeat (8) next_cycle();
        first  = 4'd4;
        second = 4'd1;
        next_cycle();
        checks++;
        if (ready !== 1'b1 || done_tick !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_idle: ready=%b done=%b, expected 1/0", ready, done_tick);
        end
        next_cycle();
        start = 1'b0;
        checks++;
        if (ready !== 1'b0 || grant !== 12'h008 || mask !== 12'h009) begin
            errors++;
            $display("[TB] FAIL b2b_second: ready=%b grant=%h mask=%h, expected 0/008/009", ready, grant, mask);
        end
        repeat (9) next_cycle();
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_drain: ready=%b, expected 1", ready);
        end
    endtask

    // Stands in for the encoder: top two set request bits become the code pair.
    task automatic test_loopback();
        logic [12:1] req;
        logic [12:1] exp_mask;
        logic [12:1] exp_grant;
        int hi;
        int lo;
        int waited;
        for (int r = 0; r < 4096; r += 7) begin
            req = r[11:0];
            hi  = 0;
            lo  = 0;
            for (int i = 12; i >= 1; i--) begin
                if (req[i] && hi == 0) hi = i;
                else if (req[i] && lo == 0) lo = i;
            end
            exp_mask  = '0;
            exp_grant = '0;
            if (hi != 0) begin
                exp_mask[hi]  = 1'b1;
                exp_grant[hi] = 1'b1;
            end
            if (lo != 0) exp_mask[lo] = 1'b1;
            do_start(hi[3:0], lo[3:0]);
            checks++;
            if (mask !== exp_mask || grant !== exp_grant || (grant & ~req) !== 12'h000) begin
                errors++;
                $display("[TB] FAIL loop_req_%h: grant=%h mask=%h, expected %h/%h", req, grant, mask, exp_grant, exp_mask);
            end
            waited = 0;
            while (ready !== 1'b1 && waited < 20) begin
                next_cycle();
                waited++;
            end
            if (ready !== 1'b1) begin
                checks++;
                errors++;
                $display("[TB] FAIL loop_timeout_%h: ready=%b, expected 1", req, ready);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_full_sequence();
        test_same_codes();
        test_invalid(4'd0, 4'd7);
        test_invalid(4'd14, 4'd0);
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_loopback();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
